// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: derives register enables and flush (bubble) requests
// from load-use, taken branches, fetch misses and data-memory waits; counts stall/flush cycles.
module hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_memread_i,
  input  logic        ex_taken_i,
  input  logic        imem_ready_i,
  input  logic        mem_req_i,
  input  logic        dmem_ready_i,
  output logic        pc_en_o,
  output logic        ifid_en_o,
  output logic        idex_en_o,
  output logic        exmem_en_o,
  output logic        memwb_en_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LU    = 2'd1,
    FLUSH = 2'd2,
    MEMW  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic loaduse;
  logic p1, p2, p3, p4;
  logic take_p2;

  always_comb begin
    loaduse = ex_memread_i && (ex_rd_i != 5'd0) &&
              ((id_uses_rs1_i && (ex_rd_i == id_rs1_i)) ||
               (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
    p1 = mem_req_i && !dmem_ready_i;
    p2 = ex_taken_i;
    p3 = loaduse;
    p4 = !imem_ready_i;
    // After a stall/flush the EX stage no longer holds the instruction that triggered it
    case (state_q)
      LU:    p3 = 1'b0;
      FLUSH: begin
        p2 = 1'b0;
        p3 = 1'b0;
      end
      MEMW:  p1 = !dmem_ready_i;
      default: ;
    endcase
  end

  always_comb begin
    pc_en_o      = 1'b1;
    ifid_en_o    = 1'b1;
    idex_en_o    = 1'b1;
    exmem_en_o   = 1'b1;
    memwb_en_o   = 1'b1;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    state_d      = RUN;
    take_p2      = 1'b0;
    if (rst_i) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_en_o    = 1'b0;
      exmem_en_o   = 1'b0;
      memwb_en_o   = 1'b0;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (p1) begin
      pc_en_o    = 1'b0;
      ifid_en_o  = 1'b0;
      idex_en_o  = 1'b0;
      exmem_en_o = 1'b0;
      memwb_en_o = 1'b0;
      state_d    = MEMW;
    end else if (p2) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      state_d      = FLUSH;
      take_p2      = 1'b1;
    end else if (p3) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_flush_o = 1'b1;
      state_d      = LU;
    end else if (p4) begin
      pc_en_o      = 1'b0;
      ifid_flush_o = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + {15'd0, (!pc_en_o && !rst_i)};
    flush_cnt_d = flush_cnt_q + {15'd0, take_p2};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: each scenario task drives inputs after the
// rising edge and checks the Mealy outputs and registered state/counters against hand values.
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        id_uses_rs1_i, id_uses_rs2_i, ex_memread_i, ex_taken_i;
  logic        imem_ready_i, mem_req_i, dmem_ready_i;
  logic        pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o;
  logic        ifid_flush_o, idex_flush_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;
  logic [1:0]  state_o;

  logic [4:0]  en;
  logic [1:0]  fl;
  assign en = {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o};
  assign fl = {ifid_flush_o, idex_flush_o};

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_stall = 16'd0;
  logic [15:0] exp_flush = 16'd0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .ex_rd_i(ex_rd_i), .ex_memread_i(ex_memread_i), .ex_taken_i(ex_taken_i),
    .imem_ready_i(imem_ready_i), .mem_req_i(mem_req_i), .dmem_ready_i(dmem_ready_i),
    .pc_en_o(pc_en_o), .ifid_en_o(ifid_en_o), .idex_en_o(idex_en_o),
    .exmem_en_o(exmem_en_o), .memwb_en_o(memwb_en_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .state_o(state_o)
  );

  task automatic set_idle();
    rst_i = 1'b0;
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; ex_rd_i = 5'd0;
    id_uses_rs1_i = 1'b0; id_uses_rs2_i = 1'b0;
    ex_memread_i = 1'b0; ex_taken_i = 1'b0;
    imem_ready_i = 1'b1; mem_req_i = 1'b0; dmem_ready_i = 1'b0;
  endtask

  task automatic set_loaduse();
    ex_memread_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_uses_rs2_i = 1'b1;
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_i = 1'b1; mem_req_i = 1'b1; ex_taken_i = 1'b1;
    #2;
    n_checks++;
    if (en !== 5'b00000) $display("FAIL rst_en actual=%b required=%b", en, 5'b00000); else n_pass++;
    n_checks++;
    if (fl !== 2'b11) $display("FAIL rst_flush actual=%b required=%b", fl, 2'b11); else n_pass++;
    tick();
    n_checks++;
    if (state_o !== 2'd0 || stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0)
      $display("FAIL rst_state actual=%0d/%0d/%0d required=0/0/0", state_o, stall_cnt_o, flush_cnt_o);
    else n_pass++;
    set_idle();
    #1;
    n_checks++;
    if (en !== 5'b11111 || fl !== 2'b00)
      $display("FAIL idle_default actual=%b/%b required=11111/00", en, fl);
    else n_pass++;
    tick();
  endtask

  task automatic test_loaduse();
    set_idle(); set_loaduse();
    #1;
    n_checks++;
    if (en !== 5'b00111 || fl !== 2'b01)
      $display("FAIL lu_out actual=%b/%b required=00111/01", en, fl);
    else n_pass++;
    tick();
    exp_stall = exp_stall + 16'd1;
    n_checks++;
    if (state_o !== 2'd1 || stall_cnt_o !== exp_stall)
      $display("FAIL lu_state actual=%0d/%0d required=1/%0d", state_o, stall_cnt_o, exp_stall);
    else n_pass++;
    // still looks like load-use, but the load has moved on
    #1;
    n_checks++;
    if (en !== 5'b11111 || fl !== 2'b00)
      $display("FAIL lu_masked actual=%b/%b required=11111/00", en, fl);
    else n_pass++;
    tick();
    set_idle();
    ex_memread_i = 1'b1; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_uses_rs1_i = 1'b1;
    #1;
    n_checks++;
    if (en !== 5'b11111 || fl !== 2'b00)
      $display("FAIL lu_x0 actual=%b/%b required=11111/00", en, fl);
    else n_pass++;
    tick();
    n_checks++;
    if (state_o !== 2'd0 || stall_cnt_o !== exp_stall)
      $display("FAIL lu_x0_state actual=%0d/%0d required=0/%0d", state_o, stall_cnt_o, exp_stall);
    else n_pass++;
  endtask

  task automatic test_branch();
    set_idle(); set_loaduse(); ex_taken_i = 1'b1;
    #1;
    n_checks++;
    if (en !== 5'b11111 || fl !== 2'b11)
      $display("FAIL br_out actual=%b/%b required=11111/11", en, fl);
    else n_pass++;
    tick();
    exp_flush = exp_flush + 16'd1;
    n_checks++;
    if (state_o !== 2'd2 || flush_cnt_o !== exp_flush || stall_cnt_o !== exp_stall)
      $display("FAIL br_state actual=%0d/%0d/%0d required=2/%0d/%0d",
               state_o, flush_cnt_o, stall_cnt_o, exp_flush, exp_stall);
    else n_pass++;
    #1;
    n_checks++;
    if (en !== 5'b11111 || fl !== 2'b00)
      $display("FAIL br_masked actual=%b/%b required=11111/00", en, fl);
    else n_pass++;
    tick();
    n_checks++;
    if (state_o !== 2'd0 || flush_cnt_o !== exp_flush || stall_cnt_o !== exp_stall)
      $display("FAIL br_after actual=%0d/%0d/%0d required=0/%0d/%0d",
               state_o, flush_cnt_o, stall_cnt_o, exp_flush, exp_stall);
    else n_pass++;
  endtask

  task automatic test_memwait();
    set_idle();
    mem_req_i = 1'b1; dmem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (en !== 5'b00000 || fl !== 2'b00)
        $display("FAIL mw_freeze%0d actual=%b/%b required=00000/00", i, en, fl);
      else n_pass++;
      tick();
      exp_stall = exp_stall + 16'd1;
      n_checks++;
      if (state_o !== 2'd3 || stall_cnt_o !== exp_stall)
        $display("FAIL mw_state%0d actual=%0d/%0d required=3/%0d", i, state_o, stall_cnt_o, exp_stall);
      else n_pass++;
    end
    dmem_ready_i = 1'b1;
    #1;
    n_checks++;
    if (en !== 5'b11111 || fl !== 2'b00)
      $display("FAIL mw_release actual=%b/%b required=11111/00", en, fl);
    else n_pass++;
    tick();
    n_checks++;
    if (state_o !== 2'd0 || stall_cnt_o !== exp_stall)
      $display("FAIL mw_after actual=%0d/%0d required=0/%0d", state_o, stall_cnt_o, exp_stall);
    else n_pass++;
  endtask

  task automatic test_priority();
    set_idle();
    mem_req_i = 1'b1; ex_taken_i = 1'b1; set_loaduse();
    #1;
    n_checks++;
    if (en !== 5'b00000 || fl !== 2'b00)
      $display("FAIL pri_p1 actual=%b/%b required=00000/00", en, fl);
    else n_pass++;
    tick();
    exp_stall = exp_stall + 16'd1;
    // memory completes while the branch is still taken in EX
    dmem_ready_i = 1'b1;
    #1;
    n_checks++;
    if (en !== 5'b11111 || fl !== 2'b11)
      $display("FAIL pri_memw_p2 actual=%b/%b required=11111/11", en, fl);
    else n_pass++;
    tick();
    exp_flush = exp_flush + 16'd1;
    n_checks++;
    if (state_o !== 2'd2 || flush_cnt_o !== exp_flush || stall_cnt_o !== exp_stall)
      $display("FAIL pri_state actual=%0d/%0d/%0d required=2/%0d/%0d",
               state_o, flush_cnt_o, stall_cnt_o, exp_flush, exp_stall);
    else n_pass++;
    set_idle();
    tick();
  endtask

  task automatic test_imem();
    set_idle();
    imem_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (en !== 5'b01111 || fl !== 2'b10)
        $display("FAIL im_out%0d actual=%b/%b required=01111/10", i, en, fl);
      else n_pass++;
      tick();
      exp_stall = exp_stall + 16'd1;
      n_checks++;
      if (state_o !== 2'd0 || stall_cnt_o !== exp_stall)
        $display("FAIL im_state%0d actual=%0d/%0d required=0/%0d", i, state_o, stall_cnt_o, exp_stall);
      else n_pass++;
    end
    set_idle();
  endtask

  task automatic test_rst_memw();
    set_idle();
    mem_req_i = 1'b1;
    tick();
    n_checks++;
    if (state_o !== 2'd3)
      $display("FAIL rm_enter actual=%0d required=3", state_o);
    else n_pass++;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (en !== 5'b00000 || fl !== 2'b11)
      $display("FAIL rm_during actual=%b/%b required=00000/11", en, fl);
    else n_pass++;
    tick();
    exp_stall = 16'd0;
    exp_flush = 16'd0;
    n_checks++;
    if (state_o !== 2'd0 || stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0)
      $display("FAIL rm_after actual=%0d/%0d/%0d required=0/0/0", state_o, stall_cnt_o, flush_cnt_o);
    else n_pass++;
    set_idle();
    #1;
    n_checks++;
    if (en !== 5'b11111 || fl !== 2'b00)
      $display("FAIL rm_release actual=%b/%b required=11111/00", en, fl);
    else n_pass++;
    tick();
    n_checks++;
    if (state_o !== 2'd0 || stall_cnt_o !== 16'd0)
      $display("FAIL rm_release_state actual=%0d/%0d required=0/0", state_o, stall_cnt_o);
    else n_pass++;
  endtask

  task automatic test_wrap();
    set_idle();
    imem_ready_i = 1'b0;
    repeat (65535) @(posedge clk_i);
    #1;
    n_checks++;
    if (stall_cnt_o !== 16'hFFFF)
      $display("FAIL wrap_full actual=%h required=%h", stall_cnt_o, 16'hFFFF);
    else n_pass++;
    tick();
    n_checks++;
    if (stall_cnt_o !== 16'h0000)
      $display("FAIL wrap_zero actual=%h required=%h", stall_cnt_o, 16'h0000);
    else n_pass++;
    set_idle();
  endtask

  initial begin
    test_reset();
    test_loaduse();
    test_branch();
    test_memwait();
    test_priority();
    test_imem();
    test_rst_memw();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
